// File: rtl/limiter_pkg.sv
// rtl/limiter_pkg.sv - shared types, constants and saturation helper for the envelope limiter
package limiter_pkg;

  typedef shortint sample_t;
  typedef logic [2:0] state_t;

  localparam int Q_BITS = 12;
  localparam logic [15:0] UNITY = 16'(1 << Q_BITS);
  localparam int DIV_CYCLES = 16;

  localparam state_t IDLE   = 3'd0;
  localparam state_t ENV    = 3'd1;
  localparam state_t DIV    = 3'd2;
  localparam state_t APPLY  = 3'd3;
  localparam state_t MAKEUP = 3'd4;
  localparam state_t OUT    = 3'd5;

  function automatic sample_t sat16(input logic signed [33:0] v);
    if (v > 34'sd32767) return 16'sh7fff;
    if (v < -34'sd32768) return 16'sh8000;
    return sample_t'(v[15:0]);
  endfunction

endpackage

// File: rtl/serial_divider.sv
// rtl/serial_divider.sv - unsigned restoring divider, one quotient bit per cycle
module serial_divider
  import limiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [15:0] divisor,
  output logic [15:0] quotient,
  output logic        done
);

  logic [15:0] rem;
  logic [15:0] low;
  logic [15:0] div_q;
  logic [4:0]  count;
  logic        busy;
  logic [16:0] trial;
  logic        fits;

  // Only the low 16 quotient bits are produced, so the caller must keep
  // dividend[31:16] below the divisor.
  assign trial = {rem, low[15]};
  assign fits  = trial >= {1'b0, div_q};
  assign done  = busy && (count == 5'(DIV_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= 1'b0;
      count    <= '0;
      rem      <= '0;
      low      <= '0;
      div_q    <= '0;
      quotient <= '0;
    end else if (start) begin
      busy     <= 1'b1;
      count    <= '0;
      rem      <= dividend[31:16];
      low      <= dividend[15:0];
      div_q    <= divisor;
      quotient <= '0;
    end else if (busy) begin
      rem      <= fits ? 16'(trial - {1'b0, div_q}) : trial[15:0];
      low      <= {low[14:0], 1'b0};
      quotient <= {quotient[14:0], fits};
      count    <= count + 5'd1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/envelope_limiter.sv
// rtl/envelope_limiter.sv - peak-envelope limiter with serial gain divide; LIMITER_MAKEUP_EN adds makeup gain
module envelope_limiter
  import limiter_pkg::*;
#(
  parameter int bits_per_level = Q_BITS,
  parameter int ATTACK_SHIFT   = 2,
  parameter int RELEASE_SHIFT  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in_sample,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] threshold,
  output logic [15:0] out_sample,
  output logic        out_valid,
  input  logic        out_ready
`ifdef LIMITER_MAKEUP_EN
  ,
  input  logic [15:0] makeup
`endif
);

  localparam logic [15:0] unity_gain = 16'(1 << bits_per_level);

  state_t      state;
  sample_t     x_q;
  logic [15:0] thr_q;
  logic [15:0] env;
  logic        bypass;
  sample_t     out_q;

  logic [15:0]        abs_x;
  logic signed [16:0] diff;
  logic signed [16:0] step;
  logic signed [17:0] env_sum;
  logic [15:0]        env_next;
  logic               bypass_now;

  logic        div_start;
  logic [15:0] div_quotient;
  logic        div_done;

  logic [15:0]        gain;
  logic signed [33:0] prod;
  logic signed [33:0] scaled;
  sample_t            y_apply;

  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == OUT);
  assign out_sample = out_q;

  // Envelope update; the new value also decides the gain path this sample.
  always_comb begin
    abs_x = '0;
    if (x_q == 16'sh8000) abs_x = 16'h7fff;
    else if (x_q < 0)     abs_x = 16'(-x_q);
    else                  abs_x = 16'(x_q);
    diff = $signed({1'b0, abs_x}) - $signed({1'b0, env});
    step = (abs_x > env) ? (diff >>> ATTACK_SHIFT) : (diff >>> RELEASE_SHIFT);
    env_sum = $signed({2'b00, env}) + $signed({step[16], step});
    if (env_sum < 0)               env_next = '0;
    else if (env_sum > 18'sd32767) env_next = 16'h7fff;
    else                           env_next = env_sum[15:0];
  end

  assign bypass_now = (env_next <= thr_q);
  assign div_start  = (state == ENV) && !bypass_now;

  serial_divider u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend ({16'd0, thr_q} << bits_per_level),
    .divisor  (env_next),
    .quotient (div_quotient),
    .done     (div_done)
  );

  assign gain    = bypass ? unity_gain : div_quotient;
  assign prod    = $signed({{18{x_q[15]}}, x_q}) * $signed({18'd0, gain});
  assign scaled  = prod >>> bits_per_level;
  assign y_apply = sat16(scaled);

`ifdef LIMITER_MAKEUP_EN
  sample_t            y_q;
  logic [15:0]        mk_q;
  logic signed [33:0] mk_prod;
  logic signed [33:0] mk_scaled;

  assign mk_prod   = $signed({{18{y_q[15]}}, y_q}) * $signed({{18{mk_q[15]}}, mk_q});
  assign mk_scaled = mk_prod >>> bits_per_level;

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q  <= '0;
      mk_q <= '0;
    end else begin
      if (in_valid && in_ready) mk_q <= makeup;
      if (state == APPLY)       y_q  <= y_apply;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      x_q    <= '0;
      thr_q  <= 16'd1;
      env    <= '0;
      bypass <= 1'b0;
      out_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_q   <= in_sample;
            thr_q <= ($signed(threshold) < 16'sd1) ? 16'd1 : threshold;
            state <= ENV;
          end
        end
        ENV: begin
          env    <= env_next;
          bypass <= bypass_now;
          state  <= bypass_now ? APPLY : DIV;
        end
        DIV: begin
          if (div_done) state <= APPLY;
        end
        APPLY: begin
`ifdef LIMITER_MAKEUP_EN
          state <= MAKEUP;
`else
          out_q <= y_apply;
          state <= OUT;
`endif
        end
`ifdef LIMITER_MAKEUP_EN
        MAKEUP: begin
          out_q <= sat16(mk_scaled);
          state <= OUT;
        end
`endif
        OUT: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_envelope_limiter.sv
// tb/tb_envelope_limiter.sv - directed bench for envelope_limiter (default and fast-attack instances)
module tb_envelope_limiter;

`ifdef LIMITER_MAKEUP_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0][15:0] in_sample;
  logic [1:0][15:0] threshold;
  logic [1:0]       in_valid;
  logic [1:0]       out_ready;
  logic in_ready0, in_ready1, out_valid0, out_valid1;
  logic [15:0] out_sample0, out_sample1;
`ifdef LIMITER_MAKEUP_EN
  logic [1:0][15:0] makeup;
`endif

  int passed = 0;
  int total = 0;

  always #5 clk = ~clk;

  envelope_limiter dut0 (
    .clk(clk), .rst(rst),
    .in_sample(in_sample[0]), .in_valid(in_valid[0]), .in_ready(in_ready0),
    .threshold(threshold[0]),
    .out_sample(out_sample0), .out_valid(out_valid0), .out_ready(out_ready[0])
`ifdef LIMITER_MAKEUP_EN
    , .makeup(makeup[0])
`endif
  );

  envelope_limiter #(.ATTACK_SHIFT(0)) dut1 (
    .clk(clk), .rst(rst),
    .in_sample(in_sample[1]), .in_valid(in_valid[1]), .in_ready(in_ready1),
    .threshold(threshold[1]),
    .out_sample(out_sample1), .out_valid(out_valid1), .out_ready(out_ready[1])
`ifdef LIMITER_MAKEUP_EN
    , .makeup(makeup[1])
`endif
  );

  function automatic logic get_ready(input int u);
    return (u == 1) ? in_ready1 : in_ready0;
  endfunction

  function automatic logic get_valid(input int u);
    return (u == 1) ? out_valid1 : out_valid0;
  endfunction

  function automatic int get_out(input int u);
    return (u == 1) ? int'($signed(out_sample1)) : int'($signed(out_sample0));
  endfunction

  function automatic int get_env(input int u);
    return (u == 1) ? int'(dut1.env) : int'(dut0.env);
  endfunction

  // Drives one sample, measures accept-to-valid latency, optionally stalls
  // the output for hold cycles, then completes the handshake.
  task automatic run_sample(input int u, input int x, input int thr, input int mk, input int hold,
                            output int lat, output int y, output bit hold_ok, output bit post_ok);
    int first_y;
    bit got;
    @(negedge clk);
    in_sample[u] = 16'(x);
    threshold[u] = 16'(thr);
`ifdef LIMITER_MAKEUP_EN
    makeup[u] = 16'(mk);
`else
    if (mk < 0) in_sample[u] = 16'(x);
`endif
    in_valid[u] = 1'b1;
    if (hold > 0) out_ready[u] = 1'b0;
    @(posedge clk);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 60) begin
      @(negedge clk);
      in_valid[u] = 1'b0;
      lat++;
      if (get_valid(u)) got = 1'b1;
    end
    y = get_out(u);
    first_y = y;
    hold_ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!get_valid(u) || get_out(u) != first_y || get_ready(u)) hold_ok = 1'b0;
    end
    out_ready[u] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    post_ok = !get_valid(u) && get_ready(u);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (in_ready0 !== 1'b1) $display("FAIL reset_in_ready0: got %b expected 1", in_ready0); else passed++;
    total++; if (in_ready1 !== 1'b1) $display("FAIL reset_in_ready1: got %b expected 1", in_ready1); else passed++;
    total++; if (out_valid0 !== 1'b0) $display("FAIL reset_out_valid0: got %b expected 0", out_valid0); else passed++;
    total++; if (out_sample0 !== 16'd0) $display("FAIL reset_out_sample0: got %0d expected 0", out_sample0); else passed++;
    total++; if (get_env(0) != 0) $display("FAIL reset_env0: got %0d expected 0", get_env(0)); else passed++;
  endtask

  task automatic test_bypass();
    int lat, y; bit h, p;
    run_sample(0, 4096, 8192, 4096, 0, lat, y, h, p);
    total++; if (lat != 3 + EXTRA) $display("FAIL bypass_latency: got %0d expected %0d", lat, 3 + EXTRA); else passed++;
    total++; if (y != 4096) $display("FAIL bypass_out: got %0d expected 4096", y); else passed++;
    total++; if (get_env(0) != 1024) $display("FAIL bypass_env: got %0d expected 1024", get_env(0)); else passed++;
    total++; if (!p) $display("FAIL bypass_handshake: got %b expected 1", p); else passed++;
  endtask

  task automatic test_divide();
    int lat, y; bit h, p;
    run_sample(1, 16384, 8192, 4096, 0, lat, y, h, p);
    total++; if (lat != 19 + EXTRA) $display("FAIL divide_latency: got %0d expected %0d", lat, 19 + EXTRA); else passed++;
    total++; if (y != 8192) $display("FAIL divide_out: got %0d expected 8192", y); else passed++;
    total++; if (get_env(1) != 16384) $display("FAIL divide_env: got %0d expected 16384", get_env(1)); else passed++;
    total++; if (!p) $display("FAIL divide_handshake: got %b expected 1", p); else passed++;
  endtask

  task automatic test_release_hold();
    int lat, y; bit h, p;
    run_sample(1, 0, 8192, 4096, 10, lat, y, h, p);
    total++; if (get_env(1) != 16320) $display("FAIL release_env: got %0d expected 16320", get_env(1)); else passed++;
    total++; if (y != 0) $display("FAIL release_out: got %0d expected 0", y); else passed++;
    total++; if (lat != 19 + EXTRA) $display("FAIL release_latency: got %0d expected %0d", lat, 19 + EXTRA); else passed++;
    total++; if (!h) $display("FAIL hold_stable: got %b expected 1", h); else passed++;
    total++; if (!p) $display("FAIL hold_handshake: got %b expected 1", p); else passed++;
  endtask

  task automatic test_full_scale();
    int lat, y; bit h, p;
    run_sample(1, -32768, 8192, 4096, 0, lat, y, h, p);
    total++; if (get_env(1) != 32767) $display("FAIL fullscale_env: got %0d expected 32767", get_env(1)); else passed++;
    total++; if (y != -8192) $display("FAIL fullscale_out: got %0d expected -8192", y); else passed++;
  endtask

  task automatic test_reset_mid_div();
    int lat, y; bit h, p;
    @(negedge clk);
    in_sample[1] = 16'd16384;
    threshold[1] = 16'd8192;
    in_valid[1] = 1'b1;
    @(posedge clk);
    repeat (6) begin
      @(negedge clk);
      in_valid[1] = 1'b0;
    end
    total++; if (in_ready1 !== 1'b0 || out_valid1 !== 1'b0) $display("FAIL middiv_busy: got ready=%b valid=%b expected 0 0", in_ready1, out_valid1); else passed++;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    total++; if (in_ready1 !== 1'b1) $display("FAIL middiv_in_ready: got %b expected 1", in_ready1); else passed++;
    total++; if (out_valid1 !== 1'b0) $display("FAIL middiv_out_valid: got %b expected 0", out_valid1); else passed++;
    total++; if (get_env(1) != 0) $display("FAIL middiv_env: got %0d expected 0", get_env(1)); else passed++;
    run_sample(1, 4096, 8192, 4096, 0, lat, y, h, p);
    total++; if (y != 4096) $display("FAIL after_reset_out: got %0d expected 4096", y); else passed++;
    total++; if (lat != 3 + EXTRA) $display("FAIL after_reset_latency: got %0d expected %0d", lat, 3 + EXTRA); else passed++;
  endtask

`ifdef LIMITER_MAKEUP_EN
  task automatic test_makeup();
    int lat, y; bit h, p;
    run_sample(0, 4096, 8192, 8192, 0, lat, y, h, p);
    total++; if (y != 8192) $display("FAIL makeup_bypass_out: got %0d expected 8192", y); else passed++;
    total++; if (lat != 4) $display("FAIL makeup_bypass_latency: got %0d expected 4", lat); else passed++;
    run_sample(1, 30000, 8192, 8192, 0, lat, y, h, p);
    total++; if (y != 16376) $display("FAIL makeup_divide_out: got %0d expected 16376", y); else passed++;
    total++; if (lat != 20) $display("FAIL makeup_divide_latency: got %0d expected 20", lat); else passed++;
  endtask
`endif

  initial begin
    in_sample = '0;
    threshold = '0;
    in_valid  = '0;
    out_ready = 2'b11;
`ifdef LIMITER_MAKEUP_EN
    makeup = {16'd4096, 16'd4096};
`endif
    test_reset();
    test_bypass();
    test_divide();
    test_release_hold();
    test_full_scale();
    test_reset_mid_div();
`ifdef LIMITER_MAKEUP_EN
    test_makeup();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
